// File: rtl/lbist_pkg.sv
// Shared LBIST definitions: default geometry and the signature-checker state encoding.
// Used by the MISR, the BIST controller and the signature checker.
package lbist_pkg;

    localparam int N_MISR_DEF  = 64;
    localparam int N_SEEDS_DEF = 16;
    localparam int SEED_AW_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_FETCH  = 3'd2,
        ST_CMP    = 3'd3,
        ST_DONE   = 3'd4,
        ST_UNLOAD = 3'd5
    } chk_state_e;

endpackage

// File: rtl/lbist_sig_shifter.sv
// Signature holding register: parallel capture from the MISR, MSB-first serial unload
// with a valid/ready handshake and a count of bits still to be delivered.
module lbist_sig_shifter #(
    parameter int N_MISR = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [N_MISR-1:0] load_data_i,
    input  logic              dump_start_i,
    input  logic              ready_i,
    output logic [N_MISR-1:0] sig_o,
    output logic              bit_o,
    output logic              valid_o,
    output logic              last_o
);

    localparam int CNT_W = $clog2(N_MISR + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N_MISR);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [N_MISR-1:0] sig_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              valid_r;
    logic              accept_s;
    logic              last_s;

    // Handshake decode: a bit is consumed when valid meets ready.
    always_comb begin
        accept_s = valid_r & ready_i;
        last_s   = accept_s & (cnt_r == CNT_ONE);
    end

    // Capture, arm and shift; the register shifts in place so a repeated unload reads zeros.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sig_r   <= {N_MISR{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            valid_r <= 1'b0;
        end else if (clr_i) begin
            sig_r   <= {N_MISR{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            valid_r <= 1'b0;
        end else if (load_i) begin
            sig_r <= load_data_i;
        end else if (dump_start_i) begin
            cnt_r   <= CNT_LOAD;
            valid_r <= 1'b1;
        end else if (accept_s) begin
            sig_r   <= {sig_r[N_MISR-2:0], 1'b0};
            cnt_r   <= cnt_r - CNT_ONE;
            valid_r <= ~last_s;
        end else begin
            sig_r   <= sig_r;
            cnt_r   <= cnt_r;
            valid_r <= valid_r;
        end
    end

    assign sig_o   = sig_r;
    assign bit_o   = sig_r[N_MISR-1];
    assign valid_o = valid_r;
    assign last_o  = last_s;

endmodule

// File: rtl/lbist_sig_checker.sv
// LBIST output-response evaluator: compares each per-seed MISR signature with the golden
// ROM, accumulates fail statistics for the run and offers serial unload of the last signature.
module lbist_sig_checker
    import lbist_pkg::*;
#(
    parameter int N_MISR  = N_MISR_DEF,
    parameter int N_SEEDS = N_SEEDS_DEF,
    parameter int SEED_AW = SEED_AW_DEF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               sess_done_i,
    input  logic [SEED_AW-1:0] seed_idx_i,
    input  logic [N_MISR-1:0]  misr_sig_i,
    output logic [SEED_AW-1:0] gold_addr_o,
    input  logic [N_MISR-1:0]  gold_data_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               pass_o,
    output logic [SEED_AW:0]   fail_cnt_o,
    output logic               first_fail_vld_o,
    output logic [SEED_AW-1:0] first_fail_o,
    output logic               overrun_o,
    input  logic               dump_req_i,
    output logic               dump_bit_o,
    output logic               dump_valid_o,
    input  logic               dump_ready_i
);

    localparam logic [SEED_AW-1:0] LAST_IDX  = SEED_AW'(N_SEEDS - 1);
    localparam logic [SEED_AW:0]   FAIL_MAX  = {(SEED_AW + 1){1'b1}};
    localparam logic [SEED_AW:0]   FAIL_ZERO = {(SEED_AW + 1){1'b0}};
    localparam logic [SEED_AW:0]   FAIL_ONE  = (SEED_AW + 1)'(1);

    chk_state_e         state_r;
    logic [SEED_AW-1:0] idx_r;
    logic               busy_r;
    logic               done_r;
    logic               pass_r;
    logic [SEED_AW:0]   fail_cnt_r;
    logic               first_vld_r;
    logic [SEED_AW-1:0] first_fail_r;
    logic               overrun_r;

    logic [N_MISR-1:0]  sig_s;
    logic               last_s;
    logic               capture_s;
    logic               dump_start_s;
    logic               mismatch_s;
    logic [SEED_AW:0]   fail_nxt_s;
    logic               overrun_evt_s;
    logic [SEED_AW-1:0] gold_addr_s;

    // Event decode; the ROM address bypasses idx_r in ARMED so the read overlaps the capture.
    always_comb begin
        capture_s     = (state_r == ST_ARMED) & sess_done_i & ~start_i;
        dump_start_s  = (state_r == ST_DONE) & dump_req_i & ~start_i;
        overrun_evt_s = sess_done_i & ((state_r == ST_FETCH) | (state_r == ST_CMP));
        mismatch_s    = (sig_s != gold_data_i);
        if (mismatch_s && (fail_cnt_r != FAIL_MAX)) begin
            fail_nxt_s = fail_cnt_r + FAIL_ONE;
        end else begin
            fail_nxt_s = fail_cnt_r;
        end
        if (state_r == ST_ARMED) begin
            gold_addr_s = seed_idx_i;
        end else begin
            gold_addr_s = idx_r;
        end
    end

    // Run-control FSM with registered status outputs; start_i overrides everything but reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r      <= ST_IDLE;
            idx_r        <= {SEED_AW{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
            fail_cnt_r   <= FAIL_ZERO;
            first_vld_r  <= 1'b0;
            first_fail_r <= {SEED_AW{1'b0}};
            overrun_r    <= 1'b0;
        end else if (start_i) begin
            state_r      <= ST_ARMED;
            busy_r       <= 1'b1;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
            fail_cnt_r   <= FAIL_ZERO;
            first_vld_r  <= 1'b0;
            first_fail_r <= {SEED_AW{1'b0}};
            overrun_r    <= 1'b0;
        end else begin
            if (overrun_evt_s) begin
                overrun_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    busy_r <= 1'b0;
                end
                ST_ARMED: begin
                    if (sess_done_i) begin
                        idx_r   <= seed_idx_i;
                        state_r <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state_r <= ST_CMP;
                end
                ST_CMP: begin
                    fail_cnt_r <= fail_nxt_s;
                    if (mismatch_s && !first_vld_r) begin
                        first_vld_r  <= 1'b1;
                        first_fail_r <= idx_r;
                    end
                    if (idx_r == LAST_IDX) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        pass_r  <= (fail_nxt_s == FAIL_ZERO) & ~overrun_r & ~overrun_evt_s;
                    end else begin
                        state_r <= ST_ARMED;
                    end
                end
                ST_DONE: begin
                    if (dump_start_s) begin
                        state_r <= ST_UNLOAD;
                    end
                end
                ST_UNLOAD: begin
                    if (last_s) begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    pass_r  <= 1'b0;
                end
            endcase
        end
    end

    lbist_sig_shifter #(
        .N_MISR (N_MISR)
    ) u_shifter (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clr_i        (start_i),
        .load_i       (capture_s),
        .load_data_i  (misr_sig_i),
        .dump_start_i (dump_start_s),
        .ready_i      (dump_ready_i),
        .sig_o        (sig_s),
        .bit_o        (dump_bit_o),
        .valid_o      (dump_valid_o),
        .last_o       (last_s)
    );

    assign gold_addr_o      = gold_addr_s;
    assign busy_o           = busy_r;
    assign done_o           = done_r;
    assign pass_o           = pass_r;
    assign fail_cnt_o       = fail_cnt_r;
    assign first_fail_vld_o = first_vld_r;
    assign first_fail_o     = first_fail_r;
    assign overrun_o        = overrun_r;

endmodule

// File: tb/tb_lbist_sig_checker.sv
// Directed bench for lbist_sig_checker: table-driven session runs plus hand-written
// sequences for overrun, restart, serial unload and asynchronous reset.
module tb_lbist_sig_checker;

    logic        clk;
    logic        rst_ni;
    logic        start;
    logic        sess_done;
    logic [3:0]  seed_idx;
    logic [63:0] misr_sig;
    logic [3:0]  gold_addr;
    logic [63:0] gold_data;
    logic        busy, done, pass_flag, first_vld, overrun;
    logic [4:0]  fail_cnt;
    logic [3:0]  first_fail;
    logic        dump_req, dump_bit, dump_valid, dump_ready;

    int n_chk;
    int n_fail;

    lbist_sig_checker dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .start_i          (start),
        .sess_done_i      (sess_done),
        .seed_idx_i       (seed_idx),
        .misr_sig_i       (misr_sig),
        .gold_addr_o      (gold_addr),
        .gold_data_i      (gold_data),
        .busy_o           (busy),
        .done_o           (done),
        .pass_o           (pass_flag),
        .fail_cnt_o       (fail_cnt),
        .first_fail_vld_o (first_vld),
        .first_fail_o     (first_fail),
        .overrun_o        (overrun),
        .dump_req_i       (dump_req),
        .dump_bit_o       (dump_bit),
        .dump_valid_o     (dump_valid),
        .dump_ready_i     (dump_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] rom_val(input logic [3:0] a);
        logic [31:0] hi;
        hi = 32'h600D_5160 ^ (32'h0000_1111 * {28'h0, a});
        return {hi, 32'hA5A5_0000 | {28'h0, a}};
    endfunction

    // Golden ROM with one-cycle registered read
    always @(posedge clk) gold_data <= rom_val(gold_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic session(input logic [3:0] idx, input logic [63:0] sig);
        @(negedge clk); sess_done = 1'b1; seed_idx = idx; misr_sig = sig;
        @(negedge clk); sess_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic dump_pulse();
        @(negedge clk); dump_req = 1'b1;
        @(negedge clk); dump_req = 1'b0;
    endtask

    task automatic collect(output int nbits, output logic [63:0] got);
        nbits = 0;
        got   = 64'h0;
        for (int c = 0; c < 400 && nbits < 64; c++) begin
            @(negedge clk);
            dump_ready = c[0];
            if (dump_valid && dump_ready) begin
                got   = {got[62:0], dump_bit};
                nbits = nbits + 1;
            end
        end
        @(negedge clk);
        dump_ready = 1'b0;
    endtask

    typedef struct {
        logic       start;
        logic [3:0] idx;
        logic       flip;
        logic [4:0] exp_fail;
        logic       exp_vld;
        logic [3:0] exp_first;
        logic       exp_done;
        logic       exp_pass;
    } vec_t;

    vec_t tbl[32];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          nb;
        logic [63:0] bits;
        logic        was_valid;

        n_chk = 0; n_fail = 0;
        rst_ni = 1'b0; start = 1'b0; sess_done = 1'b0; seed_idx = 4'h0;
        misr_sig = 64'h0; dump_req = 1'b0; dump_ready = 1'b0;

        // Run 1: all sessions match. Run 2: sessions 3 and 9 carry a flipped LSB.
        for (int i = 0; i < 16; i++) begin
            tbl[i] = '{(i == 0), 4'(i), 1'b0, 5'd0, 1'b0, 4'd0, (i == 15), (i == 15)};
        end
        for (int i = 0; i < 16; i++) begin
            tbl[16+i] = '{(i == 0), 4'(i), ((i == 3) || (i == 9)),
                          ((i >= 9) ? 5'd2 : ((i >= 3) ? 5'd1 : 5'd0)),
                          (i >= 3), ((i >= 3) ? 4'd3 : 4'd0), (i == 15), 1'b0};
        end

        repeat (2) @(negedge clk);
        chk("reset_outputs", {44'h0, busy, done, pass_flag, fail_cnt, first_vld, first_fail,
                              overrun, dump_bit, dump_valid, gold_addr}, 64'h0);
        rst_ni = 1'b1;

        for (int r = 0; r < 32; r++) begin
            if (tbl[r].start) begin
                do_start();
                chk("start_busy", {63'h0, busy}, 64'h1);
                chk("start_done", {63'h0, done}, 64'h0);
            end
            session(tbl[r].idx, rom_val(tbl[r].idx) ^ {63'h0, tbl[r].flip});
            chk($sformatf("row%0d_fail_cnt", r), {59'h0, fail_cnt}, {59'h0, tbl[r].exp_fail});
            chk($sformatf("row%0d_first_vld", r), {63'h0, first_vld}, {63'h0, tbl[r].exp_vld});
            chk($sformatf("row%0d_first", r), {60'h0, first_fail}, {60'h0, tbl[r].exp_first});
            chk($sformatf("row%0d_done", r), {63'h0, done}, {63'h0, tbl[r].exp_done});
            chk($sformatf("row%0d_busy", r), {63'h0, busy}, {63'h0, ~tbl[r].exp_done});
            chk($sformatf("row%0d_pass", r), {63'h0, pass_flag}, {63'h0, tbl[r].exp_pass});
        end

        // Overrun: second pulse one cycle later lands in FETCH and is dropped
        do_start();
        @(negedge clk); sess_done = 1'b1; seed_idx = 4'd0; misr_sig = rom_val(4'd0);
        @(negedge clk); sess_done = 1'b1; seed_idx = 4'd1; misr_sig = 64'h0;
        @(negedge clk); sess_done = 1'b0;
        @(negedge clk);
        chk("ovr_flag", {63'h0, overrun}, 64'h1);
        chk("ovr_busy_armed", {63'h0, busy}, 64'h1);
        chk("ovr_no_fail", {59'h0, fail_cnt}, 64'h0);
        for (int i = 1; i < 16; i++) session(4'(i), rom_val(4'(i)));
        chk("ovr_done", {63'h0, done}, 64'h1);
        chk("ovr_pass", {63'h0, pass_flag}, 64'h0);
        chk("ovr_fail_cnt", {59'h0, fail_cnt}, 64'h0);
        chk("ovr_sticky", {63'h0, overrun}, 64'h1);

        // Restart in CMP after a mismatching session; dump_req outside DONE ignored
        do_start();
        dump_pulse();
        chk("dump_req_armed_ignored", {63'h0, dump_valid}, 64'h0);
        @(negedge clk); sess_done = 1'b1; seed_idx = 4'd0; misr_sig = rom_val(4'd0) ^ 64'h1;
        @(negedge clk); sess_done = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("rst_fail_cleared", {59'h0, fail_cnt}, 64'h0);
        chk("rst_vld_cleared", {63'h0, first_vld}, 64'h0);
        chk("rst_busy", {63'h0, busy}, 64'h1);
        chk("rst_overrun", {63'h0, overrun}, 64'h0);
        for (int i = 0; i < 16; i++) session(4'(i), rom_val(4'(i)));
        chk("restart_run_pass", {63'h0, pass_flag}, 64'h1);
        chk("restart_run_done", {63'h0, done}, 64'h1);

        // Unload run: last session signature 8000_..._0001 (mismatches ROM)
        do_start();
        for (int i = 0; i < 15; i++) session(4'(i), rom_val(4'(i)));
        session(4'd15, 64'h8000_0000_0000_0001);
        chk("unl_fail_cnt", {59'h0, fail_cnt}, 64'h1);
        chk("unl_first", {60'h0, first_fail}, 64'hF);
        chk("unl_pass", {63'h0, pass_flag}, 64'h0);
        session(4'd2, 64'h0);
        chk("done_sess_ignored_ovr", {63'h0, overrun}, 64'h0);
        chk("done_sess_ignored_cnt", {59'h0, fail_cnt}, 64'h1);
        chk("done_held", {63'h0, done}, 64'h1);
        dump_pulse();
        chk("unl_valid", {63'h0, dump_valid}, 64'h1);
        chk("unl_msb", {63'h0, dump_bit}, 64'h1);
        collect(nb, bits);
        chk("unl_nbits", 64'(nb), 64'd64);
        chk("unl_bits", bits, 64'h8000_0000_0000_0001);
        chk("unl_valid_off", {63'h0, dump_valid}, 64'h0);
        chk("unl_done_after", {63'h0, done}, 64'h1);
        dump_pulse();
        collect(nb, bits);
        chk("unl2_nbits", 64'(nb), 64'd64);
        chk("unl2_zero_bits", bits, 64'h0);

        // Asynchronous reset mid-UNLOAD
        dump_pulse();
        @(negedge clk); dump_ready = 1'b1;
        @(negedge clk);
        was_valid = dump_valid;
        #2 rst_ni = 1'b0;
        #1;
        chk("pre_reset_valid", {63'h0, was_valid}, 64'h1);
        chk("async_reset_outputs", {44'h0, busy, done, pass_flag, fail_cnt, first_vld, first_fail,
                                    overrun, dump_bit, dump_valid, gold_addr}, 64'h0);
        dump_ready = 1'b0;
        @(negedge clk); rst_ni = 1'b1;
        session(4'd15, 64'h0);
        chk("idle_sess_ignored_busy", {63'h0, busy}, 64'h0);
        chk("idle_sess_ignored_done", {63'h0, done}, 64'h0);
        chk("idle_sess_ignored_ovr", {63'h0, overrun}, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
